// File: rtl/i2c_slave_responder.sv
// I2C target for a single-master bus: oversamples SCL/SDA, matches a 7-bit address,
// ACKs, then receives write bytes or shifts out read bytes. SDA is open-drain only.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       busy,
    output logic       rw
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic       r_byte_done;
    logic [7:0] r_shift;
    logic [7:0] r_tx_shift;
    logic       r_sda_oe;
    logic       r_busy;
    logic       r_rw;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_load;

    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;

    state_t     w_state_nx;
    logic [2:0] w_bit_cnt_nx;
    logic       w_byte_done_nx;
    logic [7:0] w_shift_nx;
    logic [7:0] w_tx_shift_nx;
    logic       w_sda_oe_nx;
    logic       w_busy_nx;
    logic       w_rw_nx;
    logic [7:0] w_rx_data_nx;
    logic       w_rx_valid_nx;
    logic       w_tx_load_nx;

    logic       w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
    logic       w_start, w_stop;
    logic [7:0] w_shift_in;

    assign w_scl_rise = r_scl_sync & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_sync & r_scl_prev;
    assign w_sda_rise = r_sda_sync & ~r_sda_prev;
    assign w_sda_fall = ~r_sda_sync & r_sda_prev;
    assign w_start    = w_sda_fall & r_scl_sync;
    assign w_stop     = w_sda_rise & r_scl_sync;
    assign w_shift_in = {r_shift[6:0], r_sda_sync};

    assign sda      = r_sda_oe ? 1'b0 : 1'bz;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_load  = r_tx_load;
    assign busy     = r_busy;
    assign rw       = r_rw;

    // Pin synchronizers; they reset to the idle-bus level so reset release never looks like START.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= scl;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= sda;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    // Protocol state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_byte_done <= 1'b0;
            r_shift     <= 8'h00;
            r_tx_shift  <= 8'h00;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_rw        <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_load   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_bit_cnt   <= w_bit_cnt_nx;
            r_byte_done <= w_byte_done_nx;
            r_shift     <= w_shift_nx;
            r_tx_shift  <= w_tx_shift_nx;
            r_sda_oe    <= w_sda_oe_nx;
            r_busy      <= w_busy_nx;
            r_rw        <= w_rw_nx;
            r_rx_data   <= w_rx_data_nx;
            r_rx_valid  <= w_rx_valid_nx;
            r_tx_load   <= w_tx_load_nx;
        end
    end

    // Next-state logic; bus conditions pre-empt any SCL edge seen in the same cycle.
    always_comb begin
        w_state_nx     = r_state;
        w_bit_cnt_nx   = r_bit_cnt;
        w_byte_done_nx = r_byte_done;
        w_shift_nx     = r_shift;
        w_tx_shift_nx  = r_tx_shift;
        w_sda_oe_nx    = r_sda_oe;
        w_busy_nx      = r_busy;
        w_rw_nx        = r_rw;
        w_rx_data_nx   = r_rx_data;
        w_rx_valid_nx  = 1'b0;
        w_tx_load_nx   = 1'b0;

        if (w_start) begin
            w_state_nx     = S_ADDR;
            w_bit_cnt_nx   = 3'd0;
            w_byte_done_nx = 1'b0;
            w_sda_oe_nx    = 1'b0;
            w_busy_nx      = 1'b0;
        end else if (w_stop) begin
            w_state_nx     = S_IDLE;
            w_bit_cnt_nx   = 3'd0;
            w_byte_done_nx = 1'b0;
            w_sda_oe_nx    = 1'b0;
            w_busy_nx      = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sda_oe_nx = 1'b0;
                end
                S_ADDR: begin
                    if (w_scl_rise && !r_byte_done) begin
                        w_shift_nx   = w_shift_in;
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_shift_in[7:1] == SLAVE_ADDR) begin
                                w_byte_done_nx = 1'b1;
                                w_rw_nx        = w_shift_in[0];
                                w_busy_nx      = 1'b1;
                            end else begin
                                w_state_nx = S_IDLE;
                            end
                        end else begin
                            w_byte_done_nx = 1'b0;
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        w_byte_done_nx = 1'b0;
                        w_sda_oe_nx    = 1'b1;
                        w_state_nx     = S_ADDR_ACK;
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_nx = 3'd0;
                        if (r_rw) begin
                            w_tx_load_nx  = 1'b1;
                            w_tx_shift_nx = tx_data;
                            w_sda_oe_nx   = ~tx_data[7];
                            w_state_nx    = S_RD_DATA;
                        end else begin
                            w_sda_oe_nx = 1'b0;
                            w_state_nx  = S_WR_DATA;
                        end
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                S_WR_DATA: begin
                    if (w_scl_rise && !r_byte_done) begin
                        w_shift_nx   = w_shift_in;
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_byte_done_nx = 1'b1;
                            w_rx_data_nx   = w_shift_in;
                            w_rx_valid_nx  = 1'b1;
                        end else begin
                            w_byte_done_nx = 1'b0;
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        w_byte_done_nx = 1'b0;
                        w_sda_oe_nx    = 1'b1;
                        w_state_nx     = S_WR_ACK;
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                S_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nx  = 1'b0;
                        w_bit_cnt_nx = 3'd0;
                        w_state_nx   = S_WR_DATA;
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                S_RD_DATA: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 3'd7) begin
                            w_sda_oe_nx  = 1'b0;
                            w_bit_cnt_nx = 3'd0;
                            w_state_nx   = S_RD_ACK;
                        end else begin
                            w_bit_cnt_nx  = r_bit_cnt + 3'd1;
                            w_tx_shift_nx = {r_tx_shift[6:0], 1'b0};
                            w_sda_oe_nx   = ~r_tx_shift[6];
                        end
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                S_RD_ACK: begin
                    // Master ACK is latched on the rise; the next byte is launched on the fall.
                    if (w_scl_rise && !r_byte_done) begin
                        if (r_sda_sync) begin
                            w_state_nx = S_IGNORE;
                            w_busy_nx  = 1'b0;
                        end else begin
                            w_byte_done_nx = 1'b1;
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        w_byte_done_nx = 1'b0;
                        w_tx_load_nx   = 1'b1;
                        w_tx_shift_nx  = tx_data;
                        w_sda_oe_nx    = ~tx_data[7];
                        w_bit_cnt_nx   = 3'd0;
                        w_state_nx     = S_RD_DATA;
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                S_IGNORE: begin
                    w_sda_oe_nx = 1'b0;
                end
                default: begin
                    w_state_nx  = S_IDLE;
                    w_sda_oe_nx = 1'b0;
                    w_busy_nx   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- I2C target (responder) for the team's single-master I2C bus. Oversamples SCL/SDA with the system clock and detects START/STOP.
- Matches a 7-bit address, ACKs, then either:
  - receives write bytes and presents them to local logic, or
  - shifts out read bytes supplied by local logic.
- SDA is open-drain: the block only ever drives low or releases. It never drives SCL (no clock stretching).

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target responds to.

Ports:
- clk  input  1  system clock; must be ≥8× SCL frequency.
- reset  input  1  asynchronous, active-high.
- scl  input  1  I2C clock from master (asynchronous to clk).
- sda  inout  1  I2C data; driven 1'b0 when sda_oe=1, else 1'bz.
- tx_data  input  8  byte to return on a read; sampled when tx_load pulses.
- rx_data  output  8  last byte received in a write transfer.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- tx_load  output  1  one-clk pulse when tx_data is captured into the shifter.
- busy  output  1  high from address match until STOP/START/NACK-end.
- rw  output  1  R/W bit of the current matched transfer (1=read).

Behaviour:
- Reset: state=IDLE, sda_oe=0 (SDA released), rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, rw=0, bit_cnt=0, shift registers=0.
  - Reset mid-transfer releases SDA immediately (asynchronous).
- Input conditioning:
  - scl and sda each pass a 2-flop synchronizer plus a previous-value flop.
  - scl_rise/scl_fall/sda_rise/sda_fall are one-clk pulses derived from the synced and previous values.
- Bus conditions (synced values):
  - START: sda_fall while scl high.
  - STOP: sda_rise while scl high.
  - START in any state (including repeated START): go to ADDR, bit_cnt=0, sda_oe=0, busy=0.
  - STOP in any state: go to IDLE, sda_oe=0, busy=0.
  - START/STOP take priority over scl edges in the same cycle.
- Bit timing:
  - Sample SDA on scl_rise.
  - Change sda_oe only on scl_fall. Never change it while SCL is high, except the release on STOP/START/reset.
  - All bytes are MSB first.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- IDLE: wait for START.
- ADDR: shift 8 bits on scl_rise. After the 8th bit's scl_rise, compare bits[7:1] to SLAVE_ADDR.
  - On match: latch rw=bit[0], busy=1. On the next scl_fall, sda_oe=1 (ACK) and go to ADDR_ACK.
  - On mismatch: go to IDLE.
- ADDR_ACK: on scl_fall, release the ACK.
  - If rw=0: sda_oe=0, go to WR_DATA.
  - If rw=1: pulse tx_load, capture tx_data, drive its MSB in the same scl_fall (sda_oe = ~tx_data[7]), go to RD_DATA.
- WR_DATA: shift 8 bits on scl_rise. After the 8th bit:
  - rx_data updates and rx_valid pulses on the following clk.
  - On the next scl_fall: sda_oe=1 (ACK), go to WR_ACK.
- WR_ACK: on scl_fall, sda_oe=0, go to WR_DATA with bit_cnt=0. Every written byte is ACKed.
- RD_DATA: on each scl_fall after a bit, drive the next bit (sda_oe = ~bit). After the 8th bit's scl_fall, sda_oe=0 and go to RD_ACK.
- RD_ACK: sample master ACK on scl_rise.
  - ACK (0): on scl_fall, pulse tx_load, load the new byte, drive its MSB, go to RD_DATA.
  - NACK (1): go to IGNORE, busy=0.
- IGNORE: hold SDA released until START or STOP.
- Latency: rx_valid and tx_load occur within 4 clk cycles of the corresponding pin-level SCL edge.
- bit_cnt is 3 bits wide plus a done flag; it wraps per byte.

Test Plan:
- Write to own address: START, 0xA0 (0x50<<1|0), data 0x3C, STOP.
  - Expect: SDA low during both ACK clocks; rx_data=0x3C; exactly one rx_valid pulse; busy 1→0 at STOP.
- Address mismatch: START, 0xA2, 0x55, STOP.
  - Expect: SDA never driven; no rx_valid; busy stays 0.
- Read: tx_data=0xA5; START, 0xA1, master clocks 8 bits then NACKs, STOP.
  - Expect: bus reads 1010_0101; one tx_load pulse; SDA released during the NACK bit.
- Multi-byte read: tx_data changes 0x11→0x22 after the first tx_load; master ACKs byte 1, NACKs byte 2.
  - Expect: bus reads 0x11 then 0x22; two tx_load pulses.
- Repeated START: START, 0xA0, 0x07, then START, 0xA1, read 1 byte, NACK, STOP.
  - Expect: rx_data=0x07; rw=1 after the second address; read proceeds correctly.
- Reset mid-write: assert reset while SDA is held low for ACK.
  - Expect: SDA immediately Z and all outputs at reset values; the next START/0xA0 transfer is ACKed normally.
